// File: rtl/imem_prefetch.sv
// imem_prefetch: instruction prefetch buffer between the core fetch port and a
// variable-latency instruction memory (req/gnt/rvalid handshake).
//
// Streams sequential words into a DEPTH-entry in-order FIFO tagged with their
// address. The core is served when its PC matches the FIFO head. Any PC
// discontinuity flushes the FIFO, discards in-flight responses and refetches.
//
// Optional feature: define IMEM_PREFETCH_BYPASS_EN to forward a response
// straight to the core when the FIFO is empty and the response address matches.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   core_addr, core_ack   core PC and consume strobe
//   core_data, core_valid instruction for core_addr and its valid flag
//   mem_req, mem_addr     registered fetch request and address
//   mem_gnt               request accepted
//   mem_rvalid, mem_rdata in-order response
module imem_prefetch #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_ack,
    output logic [31:0]       core_data,
    output logic              core_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     CntOne  = CW'(1);
    localparam logic [PW-1:0]     PtrOne  = PW'(1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [CW:0]       DepthC  = DEPTH[CW:0];

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [31:0]       fifo_data [DEPTH];

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, resp_addr_q, resp_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    // A request held ungranted across a redirect; its response must be dropped.
    logic              stale_q, stale_d;

    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;
    logic              hit, fwd, miss, redirect, accept, push, pop, hold, gnt_fire;
    logic [CW:0]       credit_sum;

    always_comb begin
        head_addr = fifo_addr[rd_ptr_q];
        head_data = fifo_data[rd_ptr_q];
        gnt_fire  = mem_req_q && mem_gnt;
        hold      = mem_req_q && !mem_gnt;

        hit  = (count_q != '0) && (head_addr == core_addr);
        miss = ((count_q != '0) && (head_addr != core_addr)) ||
               ((count_q == '0) && (outst_q == '0) && (core_addr != fetch_addr_q));
        redirect = (state_q != StIdle) && miss;
        // A response coinciding with a redirect belongs to the old stream.
        accept = (state_q == StRun) && mem_rvalid && !redirect;

`ifdef IMEM_PREFETCH_BYPASS_EN
        fwd = accept && (count_q == '0) && (resp_addr_q == core_addr);
`else
        fwd = 1'b0;
`endif
        core_valid = hit || fwd;
        core_data  = hit ? head_data : (fwd ? mem_rdata : 32'h0);
        pop        = hit && core_ack;
        push       = accept && !(fwd && core_ack);

        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        drop_d       = drop_q;
        stale_d      = stale_q;
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;

        outst_d = outst_q;
        if (gnt_fire) outst_d = outst_d + CntOne;
        if (mem_rvalid && (state_q != StIdle)) outst_d = outst_d - CntOne;

        unique case (state_q)
            StIdle: begin
                fetch_addr_d = core_addr;
                resp_addr_d  = core_addr;
                outst_d      = '0;
                state_d      = StRun;
            end
            StRun: begin
                if (redirect) begin
                    rd_ptr_d     = '0;
                    wr_ptr_d     = '0;
                    count_d      = '0;
                    fetch_addr_d = core_addr;
                    resp_addr_d  = core_addr;
                    drop_d       = outst_d;
                    stale_d      = hold;
                    state_d      = ((outst_d != '0) || hold) ? StDrain : StRun;
                end else begin
                    if (gnt_fire) fetch_addr_d = fetch_addr_q + AddrOne;
                    if (accept) resp_addr_d = resp_addr_q + AddrOne;
                    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
                    if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
                    count_d = count_q + (push ? CntOne : '0) - (pop ? CntOne : '0);
                end
            end
            StDrain: begin
                if (mem_rvalid && (drop_q != '0)) drop_d = drop_q - CntOne;
                // Only a stale held request can be granted while draining.
                if (gnt_fire) begin
                    drop_d  = drop_d + CntOne;
                    stale_d = 1'b0;
                end
                if (redirect) begin
                    fetch_addr_d = core_addr;
                    resp_addr_d  = core_addr;
                end
                if ((drop_d == '0) && !stale_d) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        credit_sum = {1'b0, count_d} + {1'b0, outst_d};
        mem_req_d  = hold || ((state_d == StRun) && (credit_sum < DepthC));
        mem_addr_d = hold ? mem_addr_q : fetch_addr_d;

        mem_req  = mem_req_q;
        mem_addr = mem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            drop_q       <= '0;
            stale_q      <= 1'b0;
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            stale_q      <= stale_d;
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= resp_addr_q;
            fifo_data[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule
